word5_capture_fifo: RTL and testbench

//  Downstream consumer of a 1-bit strobe and a [0:0][4:0] packed word from the preceding generator stage.

---
 rtl/word5_pkg.sv | 13 +
 rtl/word5_fifo_ptr.sv | 41 ++++
 rtl/word5_capture_fifo.sv | 95 +++++++++
 tb/tb_word5_capture_fifo.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/word5_pkg.sv
// Shared types and helpers for the 5-bit capture FIFO.
package word5_pkg;

    typedef logic [0:0][4:0] word5_t;

    localparam int unsigned WORD5_W = 5;

    // Even-parity bit: XOR of all data bits.
    function automatic logic word5_parity(word5_t w);
        return ^w;
    endfunction

endpackage

// File: rtl/word5_fifo_ptr.sv
// Pointer pair for the capture FIFO: write/read pointers with an extra wrap bit,
// plus the derived full, empty and occupancy level.
module word5_fifo_ptr #(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] rd_addr,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Advance pointers on accepted push / pop; reset discards all entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Status derived from the registered pointers.
    always_comb begin
        wr_addr = wr_ptr[AW-1:0];
        rd_addr = rd_ptr[AW-1:0];
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        level   = wr_ptr - rd_ptr;
    end

endmodule

// File: rtl/word5_capture_fifo.sv
// Captures a 5-bit word on every strobe into a small circular FIFO, drains it
// through a valid/ready stream and counts words lost to overflow.
// Optional feature macro: WORD5_CAPTURE_PARITY_EN (per-entry even parity,
// adds par_err output and inj_par input).
module word5_capture_fifo
    import word5_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DROP_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_strobe,
    input  word5_t                  in_word,
    output logic                    out_valid,
    input  logic                    out_ready,
    output word5_t                  out_word,
    output logic [$clog2(DEPTH):0]  level,
    output logic [DROP_W-1:0]       drop_cnt,
`ifdef WORD5_CAPTURE_PARITY_EN
    input  logic                    inj_par,
    output logic                    par_err,
`endif
    output logic                    overflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push;
    logic          drop;

    word5_t mem [DEPTH];

    // A pop frees a slot in the same cycle, so push is accepted even when full.
    always_comb begin
        pop  = !empty && out_ready;
        push = in_strobe && (!full || pop);
        drop = in_strobe && full && !pop;
    end

    word5_fifo_ptr #(.DEPTH(DEPTH)) u_ptr (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_addr (wr_addr),
        .rd_addr (rd_addr),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    // Storage write; in_word is only sampled on an accepted push so X on idle
    // cycles never enters the array.
    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_addr] <= in_word;
    end

    // Saturating drop counter and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (drop) begin
            if (drop_cnt != {DROP_W{1'b1}}) drop_cnt <= drop_cnt + 1'b1;
            overflow <= 1'b1;
        end
    end

    // Head output; gated by valid so stale or never-written entries stay hidden.
    always_comb begin
        out_valid = !empty;
        out_word  = out_valid ? mem[rd_addr] : '0;
    end

`ifdef WORD5_CAPTURE_PARITY_EN
    logic par_mem [DEPTH];

    // Parity stored alongside each entry; inj_par flips it for test.
    always_ff @(posedge clk) begin
        if (!rst && push) par_mem[wr_addr] <= word5_parity(in_word) ^ inj_par;
    end

    // Recompute head parity and compare with the stored bit.
    always_comb begin
        par_err = out_valid && (word5_parity(mem[rd_addr]) != par_mem[rd_addr]);
    end
`endif

endmodule

// File: tb/tb_word5_capture_fifo.sv
// Directed self-checking bench for word5_capture_fifo (DEPTH=4).
// A second instance with DROP_W=2 shares all inputs to check counter saturation.
module tb_word5_capture_fifo;
    import word5_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_strobe = 1'b0;
    word5_t     in_word = '0;
    logic       out_ready = 1'b0;
    logic       out_valid, out_valid2;
    word5_t     out_word, out_word2;
    logic [2:0] level, level2;
    logic [7:0] drop_cnt;
    logic [1:0] drop_cnt2;
    logic       overflow, overflow2;
`ifdef WORD5_CAPTURE_PARITY_EN
    logic       inj_par = 1'b0;
    logic       par_err, par_err2;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    word5_capture_fifo #(.DEPTH(4), .DROP_W(8)) dut (
        .clk(clk), .rst(rst), .in_strobe(in_strobe), .in_word(in_word),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .level(level), .drop_cnt(drop_cnt),
`ifdef WORD5_CAPTURE_PARITY_EN
        .inj_par(inj_par), .par_err(par_err),
`endif
        .overflow(overflow)
    );

    word5_capture_fifo #(.DEPTH(4), .DROP_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_strobe(in_strobe), .in_word(in_word),
        .out_valid(out_valid2), .out_ready(out_ready), .out_word(out_word2),
        .level(level2), .drop_cnt(drop_cnt2),
`ifdef WORD5_CAPTURE_PARITY_EN
        .inj_par(inj_par), .par_err(par_err2),
`endif
        .overflow(overflow2)
    );

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_strobe = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic push_word(input logic [4:0] w);
        in_strobe = 1'b1;
        in_word   = w;
        step();
        in_strobe = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (out_valid !== 1'b0 || level !== 3'd0 || out_word !== 5'h00 ||
            drop_cnt !== 8'd0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: valid=%b level=%0d word=%h drop=%0d ovf=%b, required 0/0/00/0/0",
                     out_valid, level, out_word, drop_cnt, overflow);
        end
    endtask

    task automatic test_fill_drain();
        logic [4:0] exp [4];
        exp[0] = 5'h01; exp[1] = 5'h01; exp[2] = 5'h07; exp[3] = 5'h1F;
        do_reset();
        for (int i = 0; i < 4; i++) push_word(exp[i]);
        tests++;
        if (level !== 3'd4 || out_valid !== 1'b1 || drop_cnt !== 8'd0) begin
            fails++;
            $display("FAIL fill_level: level=%0d valid=%b drop=%0d, required 4/1/0", level, out_valid, drop_cnt);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (out_valid !== 1'b1 || out_word !== exp[i]) begin
                fails++;
                $display("FAIL drain_word[%0d]: valid=%b word=%h, required 1/%h", i, out_valid, out_word, exp[i]);
            end
            step();
        end
        out_ready = 1'b0;
        tests++;
        if (level !== 3'd0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL drain_empty: level=%0d valid=%b, required 0/0", level, out_valid);
        end
    endtask

    task automatic test_overflow();
        logic [4:0] exp [4];
        exp[0] = 5'h03; exp[1] = 5'h0A; exp[2] = 5'h15; exp[3] = 5'h1C;
        do_reset();
        for (int i = 0; i < 4; i++) push_word(exp[i]);
        for (int i = 0; i < 3; i++) push_word(5'h1F);
        tests++;
        if (drop_cnt !== 8'd3 || overflow !== 1'b1 || level !== 3'd4) begin
            fails++;
            $display("FAIL overflow_3: drop=%0d ovf=%b level=%0d, required 3/1/4", drop_cnt, overflow, level);
        end
        for (int i = 0; i < 2; i++) push_word(5'h1E);
        tests++;
        if (drop_cnt !== 8'd5 || drop_cnt2 !== 2'd3 || overflow2 !== 1'b1) begin
            fails++;
            $display("FAIL overflow_sat: drop8=%0d drop2=%0d ovf2=%b, required 5/3/1", drop_cnt, drop_cnt2, overflow2);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (out_word !== exp[i]) begin
                fails++;
                $display("FAIL overflow_contents[%0d]: word=%h, required %h", i, out_word, exp[i]);
            end
            step();
        end
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL overflow_sticky: valid=%b ovf=%b, required 0/1", out_valid, overflow);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 1; i <= 4; i++) push_word(5'(i));
        out_ready = 1'b1;
        in_strobe = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_word = 5'(i + 5);
            tests++;
            if (level !== 3'd4 || out_word !== 5'(i + 1)) begin
                fails++;
                $display("FAIL full_pushpop[%0d]: level=%0d word=%h, required 4/%h", i, level, out_word, 5'(i + 1));
            end
            step();
        end
        in_strobe = 1'b0;
        for (int i = 11; i <= 14; i++) begin
            tests++;
            if (out_word !== 5'(i)) begin
                fails++;
                $display("FAIL full_tail[%0d]: word=%h, required %h", i, out_word, 5'(i));
            end
            step();
        end
        out_ready = 1'b0;
        tests++;
        if (drop_cnt !== 8'd0 || level !== 3'd0) begin
            fails++;
            $display("FAIL full_nodrop: drop=%0d level=%0d, required 0/0", drop_cnt, level);
        end
    endtask

    task automatic test_wrap();
        logic [4:0] q [$];
        int sent = 0;
        int got = 0;
        int cyc = 0;
        logic pop_m, push_m;
        do_reset();
        while (got < 37 && cyc < 1000) begin
            out_ready = 1'($urandom_range(0, 1));
            pop_m  = (q.size() > 0) && out_ready;
            push_m = (sent < 37) && ((q.size() < 4) || pop_m);
            in_strobe = push_m;
            in_word   = 5'((sent * 7 + 3) & 31);
            tests++;
            if (level !== 3'(q.size()) || out_valid !== (q.size() > 0)) begin
                fails++;
                $display("FAIL wrap_level cyc=%0d: level=%0d valid=%b, required %0d/%b",
                         cyc, level, out_valid, q.size(), q.size() > 0);
            end
            if (pop_m) begin
                tests++;
                if (out_word !== q[0]) begin
                    fails++;
                    $display("FAIL wrap_word[%0d]: word=%h, required %h", got, out_word, q[0]);
                end
            end
            step();
            if (pop_m) begin
                void'(q.pop_front());
                got++;
            end
            if (push_m) begin
                q.push_back(5'((sent * 7 + 3) & 31));
                sent++;
            end
            cyc++;
        end
        in_strobe = 1'b0;
        out_ready = 1'b0;
        tests++;
        if (got != 37 || drop_cnt !== 8'd0) begin
            fails++;
            $display("FAIL wrap_done: received=%0d drop=%0d, required 37/0", got, drop_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) push_word(5'(i + 16));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        tests++;
        if (level !== 3'd3 || overflow !== 1'b1 || drop_cnt !== 8'd1) begin
            fails++;
            $display("FAIL mid_pre: level=%0d ovf=%b drop=%0d, required 3/1/1", level, overflow, drop_cnt);
        end
        rst = 1'b1;
        in_strobe = 1'b1;
        in_word = 5'h11;
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        in_strobe = 1'b0;
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || level !== 3'd0 || drop_cnt !== 8'd0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: valid=%b level=%0d drop=%0d ovf=%b, required 0/0/0/0",
                     out_valid, level, drop_cnt, overflow);
        end
        push_word(5'h0B);
        tests++;
        if (out_valid !== 1'b1 || level !== 3'd1 || out_word !== 5'h0B) begin
            fails++;
            $display("FAIL mid_first: valid=%b level=%0d word=%h, required 1/1/0b", out_valid, level, out_word);
        end
    endtask

`ifdef WORD5_CAPTURE_PARITY_EN
    task automatic test_parity();
        do_reset();
        tests++;
        if (par_err !== 1'b0) begin
            fails++;
            $display("FAIL par_reset: par_err=%b, required 0", par_err);
        end
        inj_par = 1'b1;
        push_word(5'h07);
        inj_par = 1'b0;
        tests++;
        if (par_err !== 1'b1 || out_word !== 5'h07) begin
            fails++;
            $display("FAIL par_inject: par_err=%b word=%h, required 1/07", par_err, out_word);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        push_word(5'h07);
        tests++;
        if (par_err !== 1'b0 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL par_clean: par_err=%b valid=%b, required 0/1", par_err, out_valid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_full_push_pop();
        test_wrap();
        test_reset_mid();
`ifdef WORD5_CAPTURE_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
